mem_stage_ctrl: RTL and testbench

//  Consumer side of the EXE->MEM pipeline register: the MEM stage of the 5-stage core.

---
 rtl/mem_stage_ctrl_pkg.sv | 20 ++
 rtl/mem_stage_ctrl_if.sv | 48 ++++
 rtl/mem_stage_ctrl_wb_reg.sv | 63 ++++++
 rtl/mem_stage_ctrl.sv | 98 +++++++++
 tb/tb_mem_stage_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_ctrl_pkg                                                   |
// | Shared MEM-stage types: FSM encoding, register index width, defaults |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned c_MEM_BASE_DEFAULT = 1024;
  localparam int unsigned c_REG_IDX_W        = 4;
  localparam int unsigned c_CNT_W            = 8;

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_ctrl_if                                                    |
// | EXE->MEM inputs, data-memory handshake and MEM->WB outputs bundle    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_stage_ctrl_if
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                   wb_enable;
  logic                   mem_read;
  logic                   mem_write;
  logic [c_REG_IDX_W-1:0] dest;
  logic [DATA_W-1:0]      alu_res;
  logic [DATA_W-1:0]      val_rm;

  logic                   mem_req;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   mem_ready;

  logic                   freeze;
  logic                   wb_en_wb;
  logic                   mem_read_wb;
  logic [c_REG_IDX_W-1:0] dest_wb;
  logic [DATA_W-1:0]      alu_wb;
  logic [DATA_W-1:0]      mem_data_wb;
  logic                   err;

  modport master (
    input  wb_enable, mem_read, mem_write, dest, alu_res, val_rm,
    input  mem_rdata, mem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output freeze, wb_en_wb, mem_read_wb, dest_wb, alu_wb, mem_data_wb, err
  );

  modport slave (
    output wb_enable, mem_read, mem_write, dest, alu_res, val_rm,
    output mem_rdata, mem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  freeze, wb_en_wb, mem_read_wb, dest_wb, alu_wb, mem_data_wb, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl_wb_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage_reg                                                     |
// | MEM->WB pipeline register; inserts a bubble while frozen             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_wb_stage_reg
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   freeze_i,
  input  wire                   wb_enable_i,
  input  wire                   mem_read_i,
  input  wire [c_REG_IDX_W-1:0] dest_i,
  input  wire [DATA_W-1:0]      alu_res_i,
  input  wire [DATA_W-1:0]      load_data_i,
  output logic                  wb_en_o,
  output logic                  mem_read_o,
  output logic [c_REG_IDX_W-1:0] dest_o,
  output logic [DATA_W-1:0]     alu_o,
  output logic [DATA_W-1:0]     mem_data_o
);

  logic                   wb_en_q;
  logic                   mem_read_q;
  logic [c_REG_IDX_W-1:0] dest_q;
  logic [DATA_W-1:0]      alu_q;
  logic [DATA_W-1:0]      mem_data_q;
  logic [DATA_W-1:0]      mem_data_d;

  // Only loads carry memory data forward; stores and ALU ops write zero.
  assign mem_data_d = mem_read_i ? load_data_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
      dest_q     <= '0;
      alu_q      <= '0;
      mem_data_q <= '0;
    end else if (!freeze_i) begin
      wb_en_q    <= wb_enable_i;
      mem_read_q <= mem_read_i;
      dest_q     <= dest_i;
      alu_q      <= alu_res_i;
      mem_data_q <= mem_data_d;
    end else begin
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_read_o = mem_read_q;
  assign dest_o     = dest_q;
  assign alu_o      = alu_q;
  assign mem_data_o = mem_data_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_ctrl                                                       |
// | MEM stage: data-memory req/ready handshake, freeze and MEM->WB drive |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int unsigned MEM_BASE = c_MEM_BASE_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  wire               clk,
  input  wire               rst,
  mem_stage_ctrl_if.master  bus
);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  state_e               state_q;
  logic [c_CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]    buf_q;
  logic                 err_q;

  logic                 w_mem_op;
  logic                 w_conflict;
  logic                 w_access;
  logic [DATA_W-1:0]    w_offset;

  assign w_mem_op   = bus.mem_read | bus.mem_write;
  assign w_conflict = bus.mem_read & bus.mem_write;
  assign w_access   = (state_q == ST_ACCESS);
  assign w_offset   = bus.alu_res - DATA_W'(MEM_BASE);

  // Memory-side outputs decode from the state register, so an async reset drops mem_req at once.
  assign bus.mem_req   = w_access;
  assign bus.mem_we    = w_access & bus.mem_write & ~bus.mem_read;
  assign bus.mem_addr  = w_offset >> 2;
  assign bus.mem_wdata = bus.mem_we ? bus.val_rm : '0;
  assign bus.freeze    = w_access | ((state_q == ST_IDLE) & w_mem_op);
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_mem_op) begin
            state_q <= ST_ACCESS;
            if (w_conflict) err_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          count_q <= count_q + 1'b1;
          // A ready arriving on the final allowed cycle still completes normally.
          if (bus.mem_ready) begin
            buf_q   <= bus.mem_read ? bus.mem_rdata : '0;
            state_q <= ST_DONE;
          end else if (count_q == c_CNT_LAST) begin
            buf_q   <= '0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          count_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_wb_stage_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_stage_reg (
    .clk         (clk),
    .rst         (rst),
    .freeze_i    (bus.freeze),
    .wb_enable_i (bus.wb_enable),
    .mem_read_i  (bus.mem_read),
    .dest_i      (bus.dest),
    .alu_res_i   (bus.alu_res),
    .load_data_i (buf_q),
    .wb_en_o     (bus.wb_en_wb),
    .mem_read_o  (bus.mem_read_wb),
    .dest_o      (bus.dest_wb),
    .alu_o       (bus.alu_wb),
    .mem_data_o  (bus.mem_data_wb)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage_ctrl                                                    |
// | Vector table plus scoreboard of MEM->WB results for mem_stage_ctrl   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_W(32)) bus ();

  mem_stage_ctrl #(
    .DATA_W   (32),
    .MEM_BASE (1024),
    .TIMEOUT  (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        wb, rd, wr;
    logic [3:0]  dest;
    logic [31:0] alu, rm, rdata;
    int          ready_at;
    int          exp_acc;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_wb_en, exp_rd;
    logic [31:0] exp_mdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        wb_en, rd;
    logic [3:0]  dest;
    logic [31:0] alu, mdata;
  } wb_t;

  wb_t  sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic req_prev = 1'b0;
  int   req_rises = 0;

  always @(negedge clk) begin
    if (bus.mem_req && !req_prev) req_rises++;
    req_prev = bus.mem_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
    input logic [31:0] alu, input logic [31:0] rm, input logic [31:0] rdata,
    input int ready_at, input int exp_acc, input logic exp_we,
    input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
    input logic exp_wb_en, input logic exp_rd, input logic [31:0] exp_mdata,
    input logic exp_err);
    vec_t v;
    v.wb = wb; v.rd = rd; v.wr = wr; v.dest = dest;
    v.alu = alu; v.rm = rm; v.rdata = rdata;
    v.ready_at = ready_at; v.exp_acc = exp_acc; v.exp_we = exp_we;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_wb_en = exp_wb_en; v.exp_rd = exp_rd; v.exp_mdata = exp_mdata;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive_idle();
    bus.wb_enable = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.dest = '0; bus.alu_res = '0; bus.val_rm = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after MEM->WB captured the op.
  task automatic run_vec(input vec_t v, input string tag);
    int  frz, acc, bubble_bad;
    bit  done, is_mem;
    wb_t e;
    is_mem = v.rd | v.wr;
    bus.wb_enable = v.wb; bus.mem_read = v.rd; bus.mem_write = v.wr;
    bus.dest = v.dest; bus.alu_res = v.alu; bus.val_rm = v.rm; bus.mem_ready = 1'b0;
    e.wb_en = v.exp_wb_en; e.rd = v.exp_rd; e.dest = v.dest; e.alu = v.alu; e.mdata = v.exp_mdata;
    sb_q.push_back(e);
    frz = 0; acc = 0; bubble_bad = 0; done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (bus.mem_req) begin
        acc++;
        if (acc == 1) begin
          chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(v.exp_we));
          chk({tag, " mem_addr"}, bus.mem_addr, v.exp_addr);
          chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
        end
        bus.mem_ready = (acc == v.ready_at);
        bus.mem_rdata = bus.mem_ready ? v.rdata : 32'hBAD0_BAD0;
      end
      @(negedge clk);
      if (bus.freeze) begin
        frz++;
        if (frz >= 2 && (bus.wb_en_wb || bus.mem_read_wb)) bubble_bad++;
      end else begin
        done = 1;
      end
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " freeze_cycles"}, frz, is_mem ? v.exp_acc + 1 : 0);
    chk({tag, " access_cycles"}, acc, v.exp_acc);
    if (is_mem) chk({tag, " bubble"}, bubble_bad, 0);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " wb_en_wb"}, 32'(bus.wb_en_wb), 32'(e.wb_en));
      chk({tag, " mem_read_wb"}, 32'(bus.mem_read_wb), 32'(e.rd));
      chk({tag, " dest_wb"}, 32'(bus.dest_wb), 32'(e.dest));
      chk({tag, " alu_wb"}, bus.alu_wb, e.alu);
      chk({tag, " mem_data_wb"}, bus.mem_data_wb, e.mdata);
    end
    chk({tag, " err"}, 32'(bus.err), 32'(v.exp_err));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " freeze"}, 32'(bus.freeze), 32'd0);
    chk({tag, " wb_en_wb"}, 32'(bus.wb_en_wb), 32'd0);
    chk({tag, " mem_read_wb"}, 32'(bus.mem_read_wb), 32'd0);
    chk({tag, " dest_wb"}, 32'(bus.dest_wb), 32'd0);
    chk({tag, " alu_wb"}, bus.alu_wb, 32'd0);
    chk({tag, " mem_data_wb"}, bus.mem_data_wb, 32'd0);
    chk({tag, " err"}, 32'(bus.err), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int n_mem;
    int req_base;
    vec_t v;

    //            wb rd wr dst alu           rm            rdata         rdy acc we addr          wdata         wbe rdw mdata         err
    tbl[0] = mk(1, 0, 0, 3,  32'd7,        32'd0,        32'd0,        0,  0,  0, 32'd0,        32'd0,        1,  0,  32'd0,        0);
    tbl[1] = mk(1, 1, 0, 5,  32'd1032,     32'h11,       32'hDEADBEEF, 3,  3,  0, 32'd2,        32'd0,        1,  1,  32'hDEADBEEF, 0);
    tbl[2] = mk(0, 0, 1, 2,  32'd1028,     32'h55,       32'hFFFFFFFF, 1,  1,  1, 32'd1,        32'h55,       0,  0,  32'd0,        0);
    tbl[3] = mk(1, 1, 0, 9,  32'd1424,     32'd0,        32'h12345678, 1,  1,  0, 32'd100,      32'd0,        1,  1,  32'h12345678, 0);
    tbl[4] = mk(0, 0, 1, 4,  32'd1024,     32'hA5A5A5A5, 32'd0,        2,  2,  1, 32'd0,        32'hA5A5A5A5, 0,  0,  32'd0,        0);
    tbl[5] = mk(0, 0, 0, 15, 32'hFFFFFFFF, 32'd0,        32'd0,        0,  0,  0, 32'd0,        32'd0,        0,  0,  32'd0,        0);
    tbl[6] = mk(1, 1, 0, 6,  32'h13FC,     32'd0,        32'hCAFEF00D, 5,  5,  0, 32'h3FF,      32'd0,        1,  1,  32'hCAFEF00D, 0);
    tbl[7] = mk(1, 0, 1, 7,  32'd1036,     32'h0F0F,     32'hFFFFFFFF, 2,  2,  1, 32'd3,        32'h0F0F,     1,  0,  32'd0,        0);
    tbl[8] = mk(1, 1, 0, 8,  32'd0,        32'd0,        32'd1,        1,  1,  0, 32'h3FFFFF00, 32'd0,        1,  1,  32'd1,        0);
    tbl[9] = mk(1, 0, 0, 1,  32'd1032,     32'd0,        32'd0,        0,  0,  0, 32'd0,        32'd0,        1,  0,  32'd0,        0);

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;

    n_mem = 0;
    foreach (tbl[i]) if (tbl[i].rd || tbl[i].wr) n_mem++;
    req_base = req_rises;
    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("v%0d", i));
    chk("table mem_req_assertions", req_rises - req_base, n_mem);

    // Reset while a load is in ACCESS
    bus.wb_enable = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    bus.dest = 4'd12; bus.alu_res = 32'd1032; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst req_before", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("midrst req_async", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check_cleared("midrst");
    @(posedge clk); #1 rst = 1'b0;

    // Stray mem_ready while idle must be ignored
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("stray freeze", 32'(bus.freeze), 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("stray mem_req", 32'(bus.mem_req), 32'd0);
    chk("stray err", 32'(bus.err), 32'd0);
    run_vec(mk(1, 0, 0, 13, 32'd99, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 1, 0, 32'd0, 0), "after_stray");

    // Load that never completes
    v = mk(1, 1, 0, 10, 32'd1040, 32'd0, 32'h1111, 0, 255, 0, 32'd4, 32'd0, 1, 1, 32'd0, 1);
    run_vec(v, "timeout");

    rst = 1'b1; drive_idle();
    @(posedge clk); #1 rst = 1'b0;
    chk("post_timeout_rst err", 32'(bus.err), 32'd0);

    // Read and write both set: read is performed, err raised
    v = mk(1, 1, 1, 11, 32'd1040, 32'h77, 32'hBEEF, 1, 1, 0, 32'd4, 32'd0, 1, 1, 32'hBEEF, 1);
    run_vec(v, "rdwr");

    drive_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
